// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction controller: FSM state encoding,
// opcode constants, ALU select codes (also used by the ALU) and the
// opcode -> first-execute-state decode used in DECODE.
package ctrl_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD_A = 4'd3,
    LOAD_B = 4'd4,
    STORE  = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    NOOP   = 4'd8,
    HALT   = 4'd9
  } state_t;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOOP  = 4'b0000;
  localparam opcode_t OP_STORE = 4'b0001;
  localparam opcode_t OP_LOAD  = 4'b0010;
  localparam opcode_t OP_ADD   = 4'b0011;
  localparam opcode_t OP_SUB   = 4'b0100;
  localparam opcode_t OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Undefined opcodes fall through to NOOP.
  function automatic state_t decode_state(input opcode_t op);
    case (op)
      OP_STORE: return STORE;
      OP_LOAD:  return LOAD_A;
      OP_ADD:   return ADD;
      OP_SUB:   return SUB;
      OP_HALT:  return HALT;
      default:  return NOOP;
    endcase
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
// Ports: clk, reset_n (sync, active low), inc (advance by one), pc (current value).
// Incrementing past 2**PC_W-1 wraps to 0 through natural overflow.
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset_n)  pc <= '0;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller ahead of the datapath: fetches a 16-bit word from a
// synchronous instruction ROM, decodes it and drives the datapath controls one
// FSM state at a time (one instruction in flight, no overlap).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   im_addr / im_data     instruction ROM address out / read data in (1-cycle latency)
//   D_Addr, D_WriteEn     data memory address / write enable
//   MuxS                  reg-file write source (0 = memory q, 1 = ALU_Out)
//   RegF_W_addr/_W_en     reg-file write port
//   RegF_Ra_addr/_Rb_addr reg-file read ports
//   ALU_S                 ALU function select
//   halted                high while in HALT
// Optional: define CONTROL_UNIT_DEBUG_EN to add dbg_state, dbg_pc, dbg_ir,
// which mirror the state, PC and IR registers.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [3:0]         D_Addr,
  output logic               D_WriteEn,
  output logic               MuxS,
  output logic [3:0]         RegF_W_addr,
  output logic               RegF_W_en,
  output logic [3:0]         RegF_Ra_addr,
  output logic [3:0]         RegF_Rb_addr,
  output logic [2:0]         ALU_S,
  output logic               halted
`ifdef CONTROL_UNIT_DEBUG_EN
  ,
  output logic [3:0]         dbg_state,
  output logic [PC_W-1:0]    dbg_pc,
  output logic [INSTR_W-1:0] dbg_ir
`endif
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic               in_decode;

  // ROM data for the FETCH address is valid during DECODE, so IR capture
  // and PC advance both happen on the DECODE edge. PC is therefore frozen
  // in every other state, including HALT.
  assign in_decode = (state == DECODE);

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_decode),
    .pc      (pc)
  );

  // The ROM address simply follows PC; only the FETCH-cycle value matters.
  assign im_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (in_decode) ir <= im_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    D_Addr       = 4'd0;
    D_WriteEn    = 1'b0;
    MuxS         = 1'b0;
    RegF_W_addr  = 4'd0;
    RegF_W_en    = 1'b0;
    RegF_Ra_addr = 4'd0;
    RegF_Rb_addr = 4'd0;
    ALU_S        = ALU_PASS;
    halted       = 1'b0;
    case (state)
      INIT:   state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = decode_state(im_data[15:12]);
      STORE: begin
        RegF_Ra_addr = ir[11:8];
        D_Addr       = ir[7:4];
        D_WriteEn    = 1'b1;
        state_nxt    = FETCH;
      end
      LOAD_A: begin
        D_Addr    = ir[7:4];
        state_nxt = LOAD_B;
      end
      // Memory q is valid one cycle after the address; write it back now.
      LOAD_B: begin
        D_Addr      = ir[7:4];
        RegF_W_addr = ir[3:0];
        RegF_W_en   = 1'b1;
        state_nxt   = FETCH;
      end
      ADD, SUB: begin
        RegF_Ra_addr = ir[11:8];
        RegF_Rb_addr = ir[7:4];
        RegF_W_addr  = ir[3:0];
        MuxS         = 1'b1;
        ALU_S        = (state == ADD) ? ALU_ADD : ALU_SUB;
        RegF_W_en    = 1'b1;
        state_nxt    = FETCH;
      end
      NOOP:    state_nxt = FETCH;
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Execute states must always hold the opcode that selected them.
  a_add_op: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ADD) |-> (ir[15:12] == OP_ADD));
  a_sub_op: assert property (@(posedge clk) disable iff (!reset_n)
    (state == SUB) |-> (ir[15:12] == OP_SUB));
  a_one_wen: assert property (@(posedge clk) disable iff (!reset_n)
    !(D_WriteEn && RegF_W_en));

`ifdef CONTROL_UNIT_DEBUG_EN
  assign dbg_state = state;
  assign dbg_pc    = pc;
  assign dbg_ir    = ir;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int PC_W = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [PC_W-1:0] im_addr;
  logic [15:0]     im_data;
  logic [3:0]      D_Addr, RegF_W_addr, RegF_Ra_addr, RegF_Rb_addr;
  logic            D_WriteEn, MuxS, RegF_W_en, halted;
  logic [2:0]      ALU_S;
`ifdef CONTROL_UNIT_DEBUG_EN
  logic [3:0]      dbg_state;
  logic [PC_W-1:0] dbg_pc;
  logic [15:0]     dbg_ir;
`endif

  control_unit #(.PC_W(PC_W), .INSTR_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .D_Addr       (D_Addr),
    .D_WriteEn    (D_WriteEn),
    .MuxS         (MuxS),
    .RegF_W_addr  (RegF_W_addr),
    .RegF_W_en    (RegF_W_en),
    .RegF_Ra_addr (RegF_Ra_addr),
    .RegF_Rb_addr (RegF_Rb_addr),
    .ALU_S        (ALU_S),
    .halted       (halted)
`ifdef CONTROL_UNIT_DEBUG_EN
    ,
    .dbg_state    (dbg_state),
    .dbg_pc       (dbg_pc),
    .dbg_ir       (dbg_ir)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM, one cycle read latency.
  logic [15:0] rom [0:7];
  always @(posedge clk) im_data <= rom[im_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected per-cycle output bundle.
  typedef struct packed {
    logic       halted, we, wen, muxs;
    logic [2:0] alus;
    logic [3:0] daddr, waddr, ra, rb;
  } outs_t;

  typedef struct {
    outs_t           o;
    bit              chk_im;
    logic [PC_W-1:0] im;
  } rec_t;

  function automatic outs_t dut_outs();
    return {halted, D_WriteEn, RegF_W_en, MuxS, ALU_S, D_Addr, RegF_W_addr,
            RegF_Ra_addr, RegF_Rb_addr};
  endfunction

  // Instruction-level model: each fetched instruction expands into the
  // list of cycles it must occupy and what the datapath must see in each.
  rec_t            mq[$];
  logic [PC_W-1:0] mpc;
  bit              mhalt;

  task automatic model_issue();
    rec_t        r;
    logic [15:0] ins;
    ins = rom[mpc];
    r = '{o: '0, chk_im: 1'b1, im: mpc};
    mq.push_back(r);                         // fetch
    r.chk_im = 1'b0;
    mq.push_back(r);                         // decode
    mpc = mpc + 1'b1;
    case (ins[15:12])
      4'd1: begin
        r.o.ra = ins[11:8]; r.o.daddr = ins[7:4]; r.o.we = 1'b1;
        mq.push_back(r);
      end
      4'd2: begin
        r.o.daddr = ins[7:4];
        mq.push_back(r);
        r.o.waddr = ins[3:0]; r.o.wen = 1'b1;
        mq.push_back(r);
      end
      4'd3, 4'd4: begin
        r.o.ra = ins[11:8]; r.o.rb = ins[7:4]; r.o.waddr = ins[3:0];
        r.o.muxs = 1'b1; r.o.wen = 1'b1;
        r.o.alus = (ins[15:12] == 4'd3) ? 3'd1 : 3'd2;
        mq.push_back(r);
      end
      4'd5:    mhalt = 1'b1;
      default: mq.push_back(r);               // noop or undefined
    endcase
  endtask

  // Per-cycle compare. Inputs change only in the first half of a cycle,
  // so reset_n seen here is what the next rising edge samples.
  initial begin
    bit   prev_rst_n;
    rec_t r;
    prev_rst_n = 1'b0;
    forever begin
      @(negedge clk);
      if (!prev_rst_n) begin
        mq.delete();
        mpc   = '0;
        mhalt = 1'b0;
        check("reset_outs", dut_outs(), 32'h0);
        check("reset_im_addr", im_addr, 32'h0);
      end else begin
        if (mq.size() == 0) begin
          if (mhalt) begin
            r = '{o: '0, chk_im: 1'b0, im: '0};
            r.o.halted = 1'b1;
            mq.push_back(r);
          end else model_issue();
        end
        r = mq.pop_front();
        check("cycle_outs", dut_outs(), r.o);
        if (r.chk_im) check("fetch_im_addr", im_addr, r.im);
      end
      prev_rst_n = reset_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2013;   // LOAD  R3 <- D[1]
    rom[1] = 16'h3125;   // ADD   R5 = R1 + R2
    rom[2] = 16'h4125;   // SUB   R5 = R1 - R2
    rom[3] = 16'h1570;   // STORE R5 -> D[7]
    rom[4] = 16'h5000;   // HALT

    // Reset held for 3 edges, then one INIT cycle, then FETCH at address 0.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("t1_init_outs", dut_outs(), 32'h0);
    step();
    check("t1_fetch_im", im_addr, 0);

    // LOAD: fetch, decode, load_a, load_b
    step(); step(); step();
    check("t2_daddr", D_Addr, 1);
    check("t2_muxs", MuxS, 0);
    check("t2_waddr", RegF_W_addr, 3);
    check("t2_wen", RegF_W_en, 1);
    step();
    check("t2_next_fetch_im", im_addr, 1);

    step(); step();
    check("t3_add_bundle", {RegF_Ra_addr, RegF_Rb_addr, RegF_W_addr, MuxS, ALU_S, RegF_W_en},
          {4'd1, 4'd2, 4'd5, 1'b1, 3'b001, 1'b1});
    step();
    check("t3_fetch_im", im_addr, 2);
    step(); step();
    check("t3_sub_alu", ALU_S, 3'b010);
    check("t3_sub_wen", RegF_W_en, 1);

    step(); step(); step();
    check("t4_store_we", D_WriteEn, 1);
    check("t4_store_daddr", D_Addr, 7);
    check("t4_store_ra", RegF_Ra_addr, 5);
    check("t4_store_wen", RegF_W_en, 0);
    step();
    check("t4_store_one_cycle", D_WriteEn, 0);

    step(); step();
    check("t6_halted", halted, 1);
    repeat (5) step();
    check("t6_halt_stays", halted, 1);
    check("t6_pc_frozen", im_addr, 5);

    // Reset out of HALT, rerun, and abort the LOAD in its first execute cycle.
    reset_n = 1'b0;
    step();
    check("t6_reset_clears_halt", halted, 0);
    reset_n = 1'b1;
    step(); step(); step();     // fetch, decode, load_a
    check("t6_load_a_daddr", D_Addr, 1);
    reset_n = 1'b0;
    step();
    check("t6_abort_no_write", {D_WriteEn, RegF_W_en, halted}, 3'b000);
    check("t6_abort_im", im_addr, 0);

    // Wrap test: every word a noop or undefined opcode.
    for (int i = 0; i < 8; i++) rom[i] = (i % 2 == 1) ? 16'hF000 : 16'h0000;
    step();
    reset_n = 1'b1;
    step(); step();             // init -> fetch of word 0
    check("t5_first_fetch", im_addr, 0);
    repeat (3) step();
    check("t5_undef_next", im_addr, 1);
    repeat (21) step();
    check("t5_wrap_fetch", im_addr, 0);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
